// File: rtl/eight_bit_divider_module.sv
// ---------------------------------------------------------------------------
// eight_bit_divider_module
//   Iterative 8-bit unsigned restoring divider: one quotient bit per clock,
//   MSB first, so a division takes 8 cycles from the accepting edge to done.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     8-bit unsigned numerator, captured on the accepting edge
//   divisor      8-bit unsigned denominator, captured on the accepting edge
//   busy         high while the division is in progress
//   done         one-cycle pulse; quotient/remainder are valid in that cycle
//   quotient     floor(dividend / divisor), held until the next result
//   remainder    dividend mod divisor, held until the next result
//   div_by_zero  high while the held result came from a zero divisor
//
// Build option
//   DIV_ZERO_CHECK_EN  when defined, a zero divisor skips the iterations and
//                      finishes one cycle after acceptance with
//                      quotient=8'hFF, remainder=dividend, div_by_zero=1.
//                      When undefined, a zero divisor runs the normal 8
//                      iterations (which gives the same quotient/remainder)
//                      and div_by_zero is tied low.
// ---------------------------------------------------------------------------
module eight_bit_divider_module (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  count;

  // Working registers. dvd_sh starts as the dividend and shifts left each
  // iteration; its MSB feeds the partial remainder and the new quotient bit
  // enters at the LSB, so after 8 iterations it holds the quotient.
  logic [7:0]  dvd_sh;
  logic [7:0]  dvs_reg;
  logic [8:0]  prem;

  logic [9:0]  rem_sh;
  logic [9:0]  trial;
  logic [8:0]  prem_nxt;
  logic        q_bit;
  logic        zero_fast;
  logic        last_iter;
  logic        accept;

  // One restoring step: shift in the next dividend bit, trial-subtract the
  // divisor, keep the difference only if it did not go negative.
  always_comb begin
    rem_sh   = {prem, dvd_sh[7]};
    trial    = rem_sh - {2'b00, dvs_reg};
    q_bit    = ~trial[9];
    prem_nxt = q_bit ? trial[8:0] : rem_sh[8:0];
  end

`ifdef DIV_ZERO_CHECK_EN
  assign zero_fast = (dvs_reg == 8'd0);
`else
  assign zero_fast = 1'b0;
`endif

  assign last_iter = (count == 3'd7) || zero_fast;
  assign accept    = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == CALC) count <= count + 3'd1;
      else               count <= 3'd0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Operand capture and iteration; these never need a reset because they are
  // always reloaded on the accepting edge before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_sh  <= dividend;
      dvs_reg <= divisor;
      prem    <= 9'd0;
    end else if (state == CALC) begin
      dvd_sh  <= {dvd_sh[6:0], q_bit};
      prem    <= prem_nxt;
    end
  end

  // Result registers: loaded only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= 8'd0;
      remainder <= 8'd0;
    end else if (state == CALC && last_iter) begin
      if (zero_fast) begin
        quotient  <= 8'hFF;
        remainder <= dvd_sh;
      end else begin
        quotient  <= {dvd_sh[6:0], q_bit};
        remainder <= prem_nxt[7:0];
      end
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_by_zero <= 1'b0;
    else if (state == CALC && last_iter)
      div_by_zero <= zero_fast;
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/eight_bit_divider_module.md
EIGHT_BIT_DIVIDER_MODULE -- requirements
Module: eight_bit_divider_module

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned numerator; captured when start is accepted.
REQ-006 divisor  input  8  unsigned denominator; captured when start is accepted.
REQ-007 busy  output  1  high from the edge that accepts start until the edge that enters DONE.
REQ-008 done  output  1  single-cycle pulse; quotient and remainder are valid in that cycle.
REQ-009 quotient  output  8  unsigned floor(dividend/divisor).
REQ-010 remainder  output  8  unsigned dividend mod divisor.
REQ-011 div_by_zero  output  1  high while the held result came from a zero divisor (macro-dependent, REQ-027).

Function
REQ-012 The block SHALL be an iterative restoring divider, the inverse of the team's shift-add 8x8 multiplier.
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
- IDLE->CALC when start=1.
- CALC->DONE after the 8th iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-014 At the accepting edge N, the block SHALL capture dividend and divisor, clear the 9-bit partial remainder, clear the iteration counter, and set busy.
REQ-015 Each CALC edge SHALL perform one iteration, MSB first.
- Shift the next dividend bit into the partial remainder.
- Subtract divisor in a 9-bit trial.
- If the trial is non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-016 The 8th iteration SHALL occur at edge N+8; that edge SHALL load quotient and remainder, clear busy and set done.
- done is high in the cycle between edges N+8 and N+9.
- Latency from start to done is 8 cycles.
REQ-017 done SHALL deassert at edge N+9; the state SHALL return to IDLE at that edge.
REQ-018 quotient, remainder and div_by_zero SHALL hold their values until the next DONE entry or until reset.
- They are not cleared on start.
- They do not change during CALC.
REQ-019 start while in CALC or DONE SHALL be ignored; the request is not queued.
REQ-020 Input changes after the accepting edge SHALL NOT affect the result in progress.
REQ-021 start held high continuously SHALL start a new division at every IDLE cycle, giving back-to-back operations every 10 cycles.
REQ-022 All arithmetic SHALL be unsigned; the partial remainder SHALL never exceed divisor-1 after a completed iteration.

Reset
REQ-023 Asserting rst_n low SHALL immediately force the state to IDLE and the counter to 0.
- busy, done, quotient, remainder and div_by_zero go to 0, independent of clk.
REQ-024 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-026 Macro DIV_ZERO_CHECK_EN, when defined, SHALL enable the zero-divisor fast path.
- divisor=0 at the accepting edge N: skip CALC, enter DONE at edge N+1.
- Result: quotient=8'hFF, remainder=dividend, div_by_zero=1.
- busy is high for one cycle.
REQ-027 When DIV_ZERO_CHECK_EN is undefined, the divider SHALL run the normal 8 iterations for a zero divisor.
- This naturally yields quotient=8'hFF and remainder=dividend at edge N+8.
- div_by_zero SHALL be tied to 0.
REQ-028 div_by_zero SHALL be cleared on any non-zero-divisor result.

Verification
REQ-029 dividend=200, divisor=7, start pulse at edge N -> busy for 8 cycles; done at N+8 with quotient=28, remainder=4.
REQ-030 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5; results held steady between the two done pulses.
REQ-031 100/0 -> with DIV_ZERO_CHECK_EN: done at N+1, quotient=8'hFF, remainder=100, div_by_zero=1; without it: done at N+8, same quotient and remainder, div_by_zero=0.
REQ-032 Start 200/7; at N+3 pulse start with 9/3 and change the inputs -> the single done at N+8 shows 28/4; no second done follows.
REQ-033 Start 200/7; assert rst_n low at N+4 and release at N+6 -> all outputs 0 immediately; no done pulse; a subsequent 50/5 gives quotient=10, remainder=0 with 8-cycle latency.
